pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 52 +++++
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_ctrl_creg_file.sv | 77 +++++++
 rtl/pipe_ctrl.sv | 70 +++++++
 tb/tb_pipe_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: register indices, ctrl ops,
// exception codes, STATUS layout and the writable-bit mask of each register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_WRCR = 2'd1,
    OP_EXRT = 2'd2
  } ctrl_op_e;

  typedef enum logic [2:0] {
    EXP_NONE       = 3'd0,
    EXP_EXT_INT    = 3'd1,
    EXP_UNDEF      = 3'd2,
    EXP_OVERFLOW   = 3'd3,
    EXP_MISS_ALIGN = 3'd4,
    EXP_TRAP       = 3'd5,
    EXP_PRIV_VIO   = 3'd6
  } exp_code_e;

  typedef enum logic [4:0] {
    CREG_STATUS     = 5'd0,
    CREG_PRE_STATUS = 5'd1,
    CREG_EPC        = 5'd2,
    CREG_EXP_VECTOR = 5'd3,
    CREG_CAUSE      = 5'd4,
    CREG_INT_MASK   = 5'd5,
    CREG_IRQ        = 5'd6
  } creg_idx_e;

  localparam int STATUS_EXE_MODE_BIT = 0;
  localparam int STATUS_INT_EN_BIT   = 1;

  typedef struct packed {
    logic int_en;
    logic exe_mode;
  } status_t;

  localparam logic [7:0] INT_MASK_RESET = 8'hFF;

  // Bits a WRCR can change; zero for read-only and unimplemented indices.
  function automatic logic [31:0] creg_wmask(logic [4:0] idx);
    case (idx)
      CREG_STATUS, CREG_PRE_STATUS: return 32'h0000_0003;
      CREG_EPC, CREG_EXP_VECTOR:    return 32'hFFFF_FFFC;
      CREG_CAUSE:                   return 32'h0000_0007;
      CREG_INT_MASK:                return 32'h0000_00FF;
      default:                      return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side bundle of the controller: stage status in, stall/flush/redirect
// and control-register read port out.
interface pipe_ctrl_if;
  logic        if_busy;
  logic        mem_busy;
  logic        ld_hazard;
  logic [7:0]  irq;
  logic        mem_en;
  logic [29:0] mem_pc;
  logic [1:0]  mem_ctrl_op;
  logic [2:0]  mem_exp_code;
  logic [4:0]  mem_dst_addr;
  logic [31:0] mem_out;
  logic [4:0]  creg_rd_addr;
  logic [31:0] creg_rd_data;
  logic        exe_mode;
  logic        int_detect;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [29:0] new_pc;

  modport master (
    output if_busy, mem_busy, ld_hazard, irq, mem_en, mem_pc, mem_ctrl_op,
           mem_exp_code, mem_dst_addr, mem_out, creg_rd_addr,
    input  creg_rd_data, exe_mode, int_detect, if_stall, id_stall, ex_stall,
           mem_stall, if_flush, id_flush, ex_flush, mem_flush, new_pc
  );

  modport slave (
    input  if_busy, mem_busy, ld_hazard, irq, mem_en, mem_pc, mem_ctrl_op,
           mem_exp_code, mem_dst_addr, mem_out, creg_rd_addr,
    output creg_rd_data, exe_mode, int_detect, if_stall, id_stall, ex_stall,
           mem_stall, if_flush, id_flush, ex_flush, mem_flush, new_pc
  );
endinterface

// File: rtl/pipe_ctrl_creg_file.sv
// Control registers 0-6 with the decode read mux and same-cycle WRCR bypass.
// Action strobes arrive already qualified and mutually exclusive.
module creg_file
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        exc_en,
  input  logic [29:0] exc_pc,
  input  logic [2:0]  exc_code,
  input  logic        exrt_en,
  input  logic [7:0]  irq,
  input  logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output status_t     status,
  output logic [29:0] epc,
  output logic [29:0] exp_vector,
  output logic [7:0]  int_mask
);

  status_t     pre_status;
  logic [2:0]  cause;
  logic [31:0] wr_image;

  assign wr_image = wr_data & creg_wmask(wr_addr);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status     <= '0;
      pre_status <= '0;
      epc        <= '0;
      exp_vector <= '0;
      cause      <= '0;
      int_mask   <= INT_MASK_RESET;
    end else if (exc_en) begin
      epc        <= exc_pc;
      cause      <= exc_code;
      pre_status <= status;
      status     <= '0;
    end else if (exrt_en) begin
      status <= pre_status;
    end else if (wr_en) begin
      case (wr_addr)
        CREG_STATUS:     status     <= status_t'(wr_data[1:0]);
        CREG_PRE_STATUS: pre_status <= status_t'(wr_data[1:0]);
        CREG_EPC:        epc        <= wr_data[31:2];
        CREG_EXP_VECTOR: exp_vector <= wr_data[31:2];
        CREG_CAUSE:      cause      <= wr_data[2:0];
        CREG_INT_MASK:   int_mask   <= wr_data[7:0];
        default: ;
      endcase
    end
  end

  // NOTE: rd_data gets a default first so no path through the case infers a latch.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CREG_STATUS:     rd_data[1:0]  = status;
      CREG_PRE_STATUS: rd_data[1:0]  = pre_status;
      CREG_EPC:        rd_data[31:2] = epc;
      CREG_EXP_VECTOR: rd_data[31:2] = exp_vector;
      CREG_CAUSE:      rd_data[2:0]  = cause;
      CREG_INT_MASK:   rd_data[7:0]  = int_mask;
      CREG_IRQ:        rd_data[7:0]  = irq;
      default: ;
    endcase
    // Only writable indices bypass; a WRCR to IRQ must not shadow the live lines.
    if (wr_en && (wr_addr == rd_addr) && (creg_wmask(wr_addr) != '0))
      rd_data = wr_image;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush generation, exception entry/return and
// interrupt detection around the control register file.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  logic        stall;
  logic        commit;
  logic        exc_take;
  logic        exrt_take;
  logic        wr_take;
  logic        flush_all;
  status_t     status;
  logic [29:0] epc;
  logic [29:0] exp_vector;
  logic [7:0]  int_mask;

  assign stall  = bus.if_busy | bus.mem_busy;
  assign commit = bus.mem_en & ~stall;

  // Exception outranks EXRT, which outranks WRCR; at most one strobe is high.
  assign exc_take  = commit && (bus.mem_exp_code != EXP_NONE);
  assign exrt_take = commit && !exc_take && (bus.mem_ctrl_op == OP_EXRT);
  assign wr_take   = commit && !exc_take && (bus.mem_ctrl_op == OP_WRCR);
  assign flush_all = exc_take | exrt_take;

  creg_file u_creg_file (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_take),
    .wr_addr    (bus.mem_dst_addr),
    .wr_data    (bus.mem_out),
    .exc_en     (exc_take),
    .exc_pc     (bus.mem_pc),
    .exc_code   (bus.mem_exp_code),
    .exrt_en    (exrt_take),
    .irq        (bus.irq),
    .rd_addr    (bus.creg_rd_addr),
    .rd_data    (bus.creg_rd_data),
    .status     (status),
    .epc        (epc),
    .exp_vector (exp_vector),
    .int_mask   (int_mask)
  );

  assign bus.if_stall  = stall | bus.ld_hazard;
  assign bus.id_stall  = stall;
  assign bus.ex_stall  = stall;
  assign bus.mem_stall = stall;

  // A load-use hazard bubbles decode without redirecting fetch.
  assign bus.if_flush  = flush_all;
  assign bus.id_flush  = flush_all | bus.ld_hazard;
  assign bus.ex_flush  = flush_all;
  assign bus.mem_flush = flush_all;

  always_comb begin
    bus.new_pc = '0;
    if (exc_take)       bus.new_pc = exp_vector;
    else if (exrt_take) bus.new_pc = epc;
  end

  assign bus.exe_mode   = status.exe_mode;
  assign bus.int_detect = status.int_en & |(bus.irq & ~int_mask);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random traffic,
// predicted by a register-array model and checked by an independent monitor.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  typedef struct packed {
    bit        if_busy, mem_busy, ld_hazard;
    bit [7:0]  irq;
    bit        mem_en;
    bit [29:0] mem_pc;
    bit [1:0]  op;
    bit [2:0]  exc_code;
    bit [4:0]  dst;
    bit [31:0] data;
    bit [4:0]  rd;
    bit        rst_mid;
  } stim_t;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        exe_mode;
    logic        int_detect;
    logic [3:0]  stall;   // {if, id, ex, mem}
    logic [3:0]  flush;   // {if, id, ex, mem}
    logic [29:0] new_pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if bus ();
  pipe_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model[0:5];   // byte-address view of registers 0..5

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] reg_bits(int idx);
    case (idx)
      0, 1:    return 32'h3;
      2, 3:    return 32'hFFFF_FFFC;
      4:       return 32'h7;
      5:       return 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) model[i] = 32'h0;
    model[5] = 32'h0000_00FF;
  endfunction

  function automatic exp_t predict(stim_t s);
    exp_t e;
    bit   st, cm, ex, rt, wr;
    int   rd_i, dst_i;
    st = s.if_busy | s.mem_busy;
    cm = s.mem_en & !st;
    ex = cm && (s.exc_code != 0);
    rt = cm && !ex && (s.op == 2);
    wr = cm && !ex && (s.op == 1);
    rd_i  = int'(s.rd);
    dst_i = int'(s.dst);
    if (rd_i < 6)       e.rd_data = model[rd_i];
    else if (rd_i == 6) e.rd_data = {24'h0, s.irq};
    else                e.rd_data = 32'h0;
    if (wr && dst_i == rd_i && dst_i < 6) e.rd_data = s.data & reg_bits(dst_i);
    e.exe_mode   = model[0][0];
    e.int_detect = model[0][1] && ((s.irq & ~model[5][7:0]) != 8'h0);
    e.stall      = {st | s.ld_hazard, st, st, st};
    e.flush      = {ex | rt, ex | rt | s.ld_hazard, ex | rt, ex | rt};
    if (ex)      e.new_pc = model[3][31:2];
    else if (rt) e.new_pc = model[2][31:2];
    else         e.new_pc = 30'h0;
    return e;
  endfunction

  function automatic void model_update(stim_t s);
    bit st, cm;
    st = s.if_busy | s.mem_busy;
    cm = s.mem_en & !st;
    if (!cm) return;
    if (s.exc_code != 0) begin
      model[2] = {s.mem_pc, 2'b00};
      model[4] = {29'h0, s.exc_code};
      model[1] = model[0];
      model[0] = 32'h0;
    end else if (s.op == 2) begin
      model[0] = model[1];
    end else if (s.op == 1 && int'(s.dst) < 6) begin
      model[int'(s.dst)] = s.data & reg_bits(int'(s.dst));
    end
  endfunction

  task automatic apply(input stim_t s);
    bus.if_busy      = s.if_busy;
    bus.mem_busy     = s.mem_busy;
    bus.ld_hazard    = s.ld_hazard;
    bus.irq          = s.irq;
    bus.mem_en       = s.mem_en;
    bus.mem_pc       = s.mem_pc;
    bus.mem_ctrl_op  = s.op;
    bus.mem_exp_code = s.exc_code;
    bus.mem_dst_addr = s.dst;
    bus.mem_out      = s.data;
    bus.creg_rd_addr = s.rd;
  endtask

  // One clock of stimulus; the expectation is queued for the monitor.
  task automatic cycle(input stim_t s);
    @(negedge clk);
    apply(s);
    sb_q.push_back(predict(s));
    if (s.rst_mid) begin
      #3 reset = 1'b0;
      @(posedge clk);
      model_reset();
      #1 reset = 1'b1;
    end else begin
      @(posedge clk);
      if (reset) model_update(s);
    end
  endtask

  function automatic stim_t idle(logic [4:0] rd);
    stim_t s;
    s    = '0;
    s.rd = rd;
    return s;
  endfunction

  task automatic wrcr(input logic [4:0] dst, input logic [31:0] data, input logic [4:0] rd);
    stim_t s;
    s = idle(rd);
    s.mem_en = 1'b1; s.op = OP_WRCR; s.dst = dst; s.data = data;
    cycle(s);
  endtask

  task automatic excp(input logic [2:0] code, input logic [29:0] pc, input logic [1:0] op,
                      input bit busy, input logic [4:0] rd);
    stim_t s;
    s = idle(rd);
    s.mem_en = 1'b1; s.exc_code = code; s.mem_pc = pc; s.op = op; s.mem_busy = busy;
    cycle(s);
  endtask

  // Monitor: the DUT presents a result every cycle; sample mid low phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rd_data",    bus.creg_rd_data, e.rd_data);
        check("exe_mode",   32'(bus.exe_mode), 32'(e.exe_mode));
        check("int_detect", 32'(bus.int_detect), 32'(e.int_detect));
        check("stall",      32'({bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall}), 32'(e.stall));
        check("flush",      32'({bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush}), 32'(e.flush));
        check("new_pc",     32'(bus.new_pc), 32'(e.new_pc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations pending", sb_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    model_reset();
    apply(idle(5'd5));
    cycle(idle(5'd5));                       // held in reset
    cycle(idle(5'd5));
    #1 reset = 1'b1;
    cycle(idle(5'd5));                       // mask reads 0xFF after release
    cycle(idle(5'd0));

    wrcr(5'd3, 32'h0000_1000, 5'd3);         // same-cycle bypass
    cycle(idle(5'd3));
    wrcr(5'd0, 32'h0000_0003, 5'd0);         // user mode, interrupts on
    for (int i = 0; i < 3; i++) excp(3'd5, 30'h80, OP_NOP, 1'b1, 5'd4);
    excp(3'd5, 30'h80, OP_NOP, 1'b0, 5'd4);  // busy drops: single action
    cycle(idle(5'd2));
    wrcr(5'd0, 32'h0000_0003, 5'd0);
    excp(3'd3, 30'h40, OP_NOP, 1'b0, 5'd1);  // new_pc from EXP_VECTOR
    cycle(idle(5'd2));
    cycle(idle(5'd4));
    cycle(idle(5'd0));
    excp(3'd0, 30'h0, OP_EXRT, 1'b0, 5'd0);  // return to EPC
    cycle(idle(5'd0));
    excp(3'd6, 30'h44, OP_EXRT, 1'b0, 5'd0); // exception beats EXRT
    cycle(idle(5'd1));

    s = idle(5'd0); s.ld_hazard = 1'b1;
    cycle(s);
    wrcr(5'd0, 32'h0000_0002, 5'd0);
    wrcr(5'd5, 32'hFFFF_FFFE, 5'd5);
    s = idle(5'd6); s.irq = 8'h01; cycle(s);
    s = idle(5'd6); s.irq = 8'h02; cycle(s);
    wrcr(5'd5, 32'h0000_00FF, 5'd5);
    s = idle(5'd6); s.irq = 8'h01; cycle(s);
    wrcr(5'd6, 32'hFFFF_FFFF, 5'd6);         // read-only index ignored
    wrcr(5'd9, 32'hFFFF_FFFF, 5'd9);
    cycle(idle(5'd0));

    s = idle(5'd3); s.mem_en = 1'b1; s.op = OP_WRCR; s.dst = 5'd3;
    s.data = 32'h0000_ABC0; s.rst_mid = 1'b1;
    cycle(s);                                // reset discards the write
    cycle(idle(5'd3));
    cycle(idle(5'd5));

    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.if_busy   = ($urandom % 8) == 0;
      s.mem_busy  = ($urandom % 6) == 0;
      s.ld_hazard = ($urandom % 8) == 0;
      s.irq       = 8'($urandom);
      s.mem_en    = ($urandom % 4) != 0;
      s.mem_pc    = 30'($urandom);
      s.op        = 2'($urandom);
      s.exc_code  = (($urandom % 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      s.dst       = 5'($urandom_range(0, 9));
      s.data      = $urandom;
      s.rd        = 5'($urandom_range(0, 8));
      s.rst_mid   = ($urandom % 64) == 0;
      cycle(s);
    end

    repeat (3) @(negedge clk);
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
